// File: rtl/dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher: legal ALU opcodes,
// dispatcher FSM state encoding and the opcode legality check.
package dispatcher_pkg;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_AND  = 8'h03;
  localparam logic [7:0] OP_OR   = 8'h04;
  localparam logic [7:0] OP_XOR  = 8'h05;
  localparam logic [7:0] OP_NOT  = 8'h06;
  localparam logic [7:0] OP_SHL  = 8'h07;
  localparam logic [7:0] OP_SHR  = 8'h08;
  localparam logic [7:0] OP_INC  = 8'h09;
  localparam logic [7:0] OP_DEC  = 8'h0A;
  localparam logic [7:0] OP_NAND = 8'h0B;
  localparam logic [7:0] OP_XNOR = 8'h0C;

  localparam logic [7:0] OP_MIN  = OP_ADD;
  localparam logic [7:0] OP_MAX  = OP_XNOR;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_CORE = 2'd1,
    ISSUE     = 2'd2
  } disp_state_e;

  function automatic logic is_legal_opcode(input logic [7:0] op);
    return (op >= OP_MIN) && (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers/count and a combinational head.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/instr_dispatcher.sv
// Buffers ALU instructions and issues them round-robin to NUM_CORES cores.
// Optional DISPATCH_TRAP_EN: illegal opcodes raise a sticky trap that blocks input.
module instr_dispatcher
  import dispatcher_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int OPERAND_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef DISPATCH_TRAP_EN
  output logic                          trap,
  input  logic                          trap_clear,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_opcode,
  input  logic [OPERAND_W-1:0]          in_op_a,
  input  logic [OPERAND_W-1:0]          in_op_b,
  output logic [NUM_CORES-1:0]          out_valid,
  input  logic [NUM_CORES-1:0]          out_ready,
  output logic [7:0]                    out_opcode,
  output logic [OPERAND_W-1:0]          out_op_a,
  output logic [OPERAND_W-1:0]          out_op_b,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    illegal_count,
  output logic                          busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(NUM_CORES);
  localparam int IW = 8 + 2 * OPERAND_W;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [TW-1:0] core_add(input logic [TW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return TW'(s);
  endfunction

  disp_state_e            state_q, state_d;
  logic [TW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]          target_q, target_d;
  logic [NUM_CORES-1:0]   out_valid_q, out_valid_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [OPERAND_W-1:0]   op_a_q, op_a_d;
  logic [OPERAND_W-1:0]   op_b_q, op_b_d;
  logic [7:0]             illegal_q, illegal_d;
  logic                   in_ready_q, in_ready_d;
  logic                   trap_q, trap_d;

  logic                   accept, legal, fifo_wr, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [IW-1:0]          fifo_rd_data;
  logic [CW-1:0]          fifo_count_nxt;
  logic [NUM_CORES-1:0]   ready_rot;
  logic                   found;
  logic [TW-1:0]          sel;

  sync_fifo #(
    .WIDTH (IW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data ({in_opcode, in_op_a, in_op_b}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Rotate readiness so bit 0 is rr_ptr; the lowest set bit is the next core.
  always_comb begin
    ready_rot = NUM_CORES'({out_ready, out_ready} >> rr_ptr_q);
    found     = 1'b0;
    sel       = rr_ptr_q;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (ready_rot[k]) begin
        found = 1'b1;
        sel   = core_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    target_d    = target_q;
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    fifo_pop    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (!fifo_empty) begin
          fifo_pop                   = 1'b1;
          {opcode_d, op_a_d, op_b_d} = fifo_rd_data;
          state_d                    = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (found) begin
          target_d    = sel;
          out_valid_d = NUM_CORES'(1) << sel;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Offer is held, target fixed, until the selected core takes it.
        if (out_ready[target_q]) begin
          rr_ptr_d    = core_add(target_q, 1);
          out_valid_d = '0;
          if (!fifo_empty) begin
            fifo_pop                   = 1'b1;
            {opcode_d, op_a_d, op_b_d} = fifo_rd_data;
            state_d                    = WAIT_CORE;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    accept         = in_valid && in_ready_q;
    legal          = is_legal_opcode(in_opcode);
    fifo_wr        = accept && legal && !fifo_full;
    illegal_d      = (accept && !legal) ? sat_inc(illegal_q) : illegal_q;
    fifo_count_nxt = fifo_count + CW'(fifo_wr) - CW'(fifo_pop);
`ifdef DISPATCH_TRAP_EN
    trap_d         = (trap_q && !trap_clear) || (accept && !legal);
`else
    trap_d         = 1'b0;
`endif
    in_ready_d     = (fifo_count_nxt != CW'(FIFO_DEPTH)) && !trap_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= '0;
      target_q    <= '0;
      out_valid_q <= '0;
      opcode_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      illegal_q   <= '0;
      in_ready_q  <= 1'b1;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      target_q    <= target_d;
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      illegal_q   <= illegal_d;
      in_ready_q  <= in_ready_d;
      trap_q      <= trap_d;
    end
  end

`ifdef DISPATCH_TRAP_EN
  assign trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_opcode    = opcode_q;
  assign out_op_a      = op_a_q;
  assign out_op_b      = op_b_q;
  assign illegal_count = illegal_q;
  assign busy          = (fifo_count != '0) || (state_q != EMPTY);

endmodule

// File: tb/tb_instr_dispatcher.sv
// Self-checking bench for instr_dispatcher: directed scenarios plus random
// traffic, scored against an in-order queue and round-robin reference model.
module tb_instr_dispatcher;

  localparam int N = 4;
  localparam int D = 8;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_opcode = '0;
  logic [W-1:0]   in_op_a = '0;
  logic [W-1:0]   in_op_b = '0;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready = '0;
  logic [7:0]     out_opcode;
  logic [W-1:0]   out_op_a;
  logic [W-1:0]   out_op_b;
  logic [$clog2(D):0] fifo_count;
  logic [7:0]     illegal_count;
  logic           busy;
`ifdef DISPATCH_TRAP_EN
  logic           trap;
  logic           trap_clear = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_dispatcher #(.NUM_CORES(N), .FIFO_DEPTH(D), .OPERAND_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef DISPATCH_TRAP_EN
    .trap          (trap),
    .trap_clear    (trap_clear),
`endif
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_op_a       (in_op_a),
    .in_op_b       (in_op_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .fifo_count    (fifo_count),
    .illegal_count (illegal_count),
    .busy          (busy)
  );

  typedef struct packed {
    logic [7:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } ins_t;

  ins_t exp_q[$];
  int   model_rr = 0;
  int   exp_illegal = 0;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit legal_op(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h0C);
  endfunction

  function automatic int first_ready(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, score the edge, check #1 after it.
  task automatic cycle(input logic iv, input logic [7:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [N-1:0] rdy);
    logic [N-1:0] v0;
    ins_t bus0, got, e;
    bit   acc;
    int   core, fr;
    in_valid = iv; in_opcode = op; in_op_a = a; in_op_b = b; out_ready = rdy;
    #1;
    v0   = out_valid;
    bus0 = {out_opcode, out_op_a, out_op_b};
    acc  = iv && in_ready;
    if ((v0 & rdy) != '0) begin
      chk("onehot", $countones(v0), 1);
      core = 0;
      for (int i = 0; i < N; i++) if (v0[i]) core = i;
      chk("issue_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("issued_instr", bus0, got);
      end
      model_rr = (core + 1) % N;
    end
    if (acc) begin
      if (legal_op(op)) begin
        e = {op, a, b};
        exp_q.push_back(e);
      end else if (exp_illegal < 255) begin
        exp_illegal++;
      end
    end
    @(posedge clk);
    #1;
    chk("illegal_count", illegal_count, exp_illegal);
    if (v0 != '0 && (v0 & rdy) == '0) begin
      chk("stall_valid", out_valid, v0);
      chk("stall_bus", {out_opcode, out_op_a, out_op_b}, bus0);
    end
    if (v0 == '0 && out_valid != '0) begin
      fr = first_ready(rdy, model_rr);
      chk("rr_target", out_valid, (fr < 0) ? 0 : (1 << fr));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [N-1:0] rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, '0, '0, rdy);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bus", {out_opcode, out_op_a, out_op_b}, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_illegal", illegal_count, 0);
    chk("rst_busy", busy, 0);
`ifdef DISPATCH_TRAP_EN
    chk("rst_trap", trap, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_rr = 0;
    exp_illegal = 0;
  endtask

  initial begin
    logic [7:0] ops [6];
    logic [7:0] rop;
    @(negedge clk);
    do_reset();

    // Single instruction latency and bus contents
    cycle(1'b1, 8'h01, 8'd3, 8'd4, '1);
    cycle(1'b0, 8'h00, '0, '0, '1);
    chk("lat_early", out_valid, 0);
    cycle(1'b0, 8'h00, '0, '0, '1);
    chk("lat_valid", out_valid, 4'b0001);
    chk("lat_bus", {out_opcode, out_op_a, out_op_b}, {8'h01, 8'd3, 8'd4});
    chk("lat_busy", busy, 1);
    cycle(1'b0, 8'h00, '0, '0, '1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);

    // Round-robin over four cores, then wrap
    do_reset();
    for (int i = 2; i <= 5; i++) cycle(1'b1, 8'(i), 8'(i), 8'(i + 16), '1);
    idle(10, '1);
    cycle(1'b1, 8'h06, 8'h66, 8'h77, '1);
    cycle(1'b0, 8'h00, '0, '0, '1);
    cycle(1'b0, 8'h00, '0, '0, '1);
    chk("rr_wrap_core0", out_valid, 4'b0001);
    idle(3, '1);
    chk("rr_drained", exp_q.size(), 0);

    // Illegal opcodes mixed with legal ones
    do_reset();
    ops[0] = 8'h02; ops[1] = 8'h00; ops[2] = 8'h0D;
    ops[3] = 8'h03; ops[4] = 8'hFF; ops[5] = 8'h04;
    for (int i = 0; i < 6; i++) cycle(1'b1, ops[i], 8'(i), 8'(i * 3), '1);
    idle(10, '1);
`ifndef DISPATCH_TRAP_EN
    chk("illegal_total", illegal_count, 3);
`endif
    chk("illegal_drained", exp_q.size(), 0);

`ifdef DISPATCH_TRAP_EN
    do_reset();
    trap_clear = 1'b0;
    cycle(1'b1, 8'h00, '0, '0, '1);
    chk("trap_set", trap, 1);
    chk("trap_blocks", in_ready, 0);
    cycle(1'b1, 8'h02, 8'h11, 8'h22, '1);
    chk("trap_sticky", trap, 1);
    chk("trap_still_blocks", in_ready, 0);
    trap_clear = 1'b1;
    cycle(1'b0, 8'h00, '0, '0, '1);
    trap_clear = 1'b0;
    chk("trap_cleared", trap, 0);
    chk("trap_ready", in_ready, 1);
`endif

    // Fill with all cores stalled, then release
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(1 + i % 12), 8'(i), 8'(255 - i), '0);
    chk("full_accepted", exp_q.size(), 9);
    chk("full_count", fifo_count, 8);
    chk("full_in_ready", in_ready, 0);
    cycle(1'b1, 8'h07, 8'h55, 8'h55, '0);
    chk("full_hold_count", fifo_count, 8);
    idle(30, '1);
    chk("full_drained", exp_q.size(), 0);
    chk("full_idle", busy, 0);

    // Target stalls after selection: no reselection, bus stable
    do_reset();
    cycle(1'b1, 8'h0A, 8'h05, 8'h06, 4'b0010);
    cycle(1'b0, 8'h00, '0, '0, 4'b0010);
    cycle(1'b0, 8'h00, '0, '0, 4'b0010);
    chk("stall_sel", out_valid, 4'b0010);
    idle(5, 4'b1101);
    chk("stall_hold", out_valid, 4'b0010);
    chk("stall_hold_bus", {out_opcode, out_op_a, out_op_b}, {8'h0A, 8'h05, 8'h06});
    cycle(1'b0, 8'h00, '0, '0, '1);
    chk("stall_done", out_valid, 0);

    // Reset while an instruction is offered and three are queued
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(2 + i), 8'(i), 8'(i), '0);
    cycle(1'b1, 8'hEE, '0, '0, '0);
    cycle(1'b0, 8'h00, '0, '0, 4'b0001);
    chk("pre_rst_valid", out_valid, 4'b0001);
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_illegal", illegal_count, 1);
    do_reset();
    idle(8, '1);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_valid", out_valid, 0);

`ifndef DISPATCH_TRAP_EN
    // Saturation of the illegal counter
    do_reset();
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'hFF, '0, '0, '1);
    chk("illegal_sat", illegal_count, 255);
`endif

    // Random traffic against the reference model
    do_reset();
`ifdef DISPATCH_TRAP_EN
    trap_clear = 1'b1;
`endif
    for (int i = 0; i < 400; i++) begin
      rop = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(1, 12));
      cycle(1'($urandom_range(0, 1)), rop, W'($urandom), W'($urandom), N'($urandom));
    end
    for (int i = 0; i < 60 && busy; i++) cycle(1'b0, 8'h00, '0, '0, '1);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", busy, 0);
`ifdef DISPATCH_TRAP_EN
    trap_clear = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
- Producer side of the opcode interface consumed by each core's Controller.
- Accepts a stream of ALU instructions (8-bit opcode plus two operands) and buffers them in a FIFO.
- Issues each instruction to one of NUM_CORES processing cores, round-robin, over a shared bus with one-hot valid/ready.
- Rejects opcodes outside the Controller's legal set (0x01..0x0C) at enqueue.

Parameters:
- NUM_CORES, 4: number of cores served; 2..8.
- FIFO_DEPTH, 8: instruction buffer entries; power of 2, >= 2.
- OPERAND_W, 8: operand width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  dispatcher can accept.
- in_opcode  in  8  instruction opcode.
- in_op_a  in  OPERAND_W  operand A.
- in_op_b  in  OPERAND_W  operand B.
- out_valid  out  NUM_CORES  one-hot: instruction offered to core i.
- out_ready  in  NUM_CORES  core i idle/accepting.
- out_opcode  out  8  shared bus opcode.
- out_op_a  out  OPERAND_W  shared bus operand A.
- out_op_b  out  OPERAND_W  shared bus operand B.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.
- illegal_count  out  8  rejected opcodes, saturating.
- busy  out  1  FIFO non-empty or instruction in flight.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_opcode/op_a/op_b=0, fifo_count=0, illegal_count=0, busy=0, rr_ptr=0, state=EMPTY.
- Reset takes effect immediately. FIFO contents and any in-flight instruction are discarded.
- in_ready is registered; it equals !full for the next cycle.
- Upstream handshake: in_valid & in_ready at a rising edge.
- Legal opcode (0x01..0x0C): written to FIFO.
- Illegal opcode (0x00, 0x0D..0xFF): still consumed, not written; illegal_count increments and saturates at 255.
- FIFO write and pop in the same cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM, state EMPTY: if FIFO non-empty, pop head into output register and go to WAIT_CORE.
- FSM, state WAIT_CORE: scan from rr_ptr upward, wrapping, for the first core with out_ready=1.
  - Core found: latch it as target, go to ISSUE.
  - None found: stay in WAIT_CORE.
- FSM, state ISSUE: out_valid[target]=1 (registered); bus holds the instruction.
  - out_valid is never withdrawn, and target never changes, until out_ready[target]=1.
  - On handshake: rr_ptr = (target+1) mod NUM_CORES.
  - Then, if FIFO non-empty: pop the next entry in the same edge and go to WAIT_CORE.
  - Otherwise: clear out_valid and go to EMPTY.
- Latency: out_valid rises 2 cycles after the accepting edge, when the dispatcher was idle and a core was ready.
- Throughput: one instruction per 2 cycles when cores are always ready.
- out_ready dropping after target selection only stalls ISSUE; no reselection.
- busy = (fifo_count != 0) | (state != EMPTY).

Optional Feature:
- Macro: DISPATCH_TRAP_EN.
- Defined:
  - Adds ports trap (out, 1, reset 0) and trap_clear (in, 1).
  - An illegal opcode sets trap, sticky, on the accepting edge and forces in_ready=0 until a trap_clear pulse.
  - illegal_count still increments.
  - Issue of already-buffered instructions continues.
- Undefined: illegal opcodes are silently dropped and counted; no trap ports.

Decomposition:
- dispatcher_pkg holds:
  - Opcode constants OP_ADD=8'h01 through OP_XNOR=8'h0C, and OP_MIN/OP_MAX.
  - FSM state encoding EMPTY/WAIT_CORE/ISSUE.
  - is_legal_opcode function.
- One sub-module: sync_fifo, parameterised width/depth, with full/empty/count outputs.
- The top level holds the FSM, round-robin arbiter and counters.

Test Plan:
- Reset, then push opcode 0x01 with a=3, b=4, all cores ready -> out_valid=4'b0001 two cycles later; bus shows 0x01/3/4; handshake; busy=0 one cycle later.
- Push 4 legal opcodes 0x02..0x05, all cores ready -> issued to cores 0,1,2,3 in order, then wrap to core 0 for a fifth push.
- Push 0x00, 0x0D and 0xFF among legal ops -> only legal ops appear on the bus; illegal_count=3. With DISPATCH_TRAP_EN: trap=1 and in_ready=0 after 0x00, until a trap_clear pulse.
- Hold all out_ready=0, push 9 ops with FIFO_DEPTH=8 -> in_ready=0 after 8 buffered (one held in output register), fifo_count=8; release cores -> all 9 issued in order.
- Core 1 selected, then out_ready[1] drops for 5 cycles -> out_valid stays 4'b0010 with a stable bus, no reselection.
- Assert reset while in ISSUE with 3 queued -> out_valid=0 immediately, fifo_count=0, illegal_count=0; no stale op issued after release.
